// File: rtl/bloke2b_msg_packer.sv
// Purpose : packs a byte stream into 128-byte BLAKE2b blocks and emits them as 16 LE 64-bit words with t and final.
// Latency : a block starts emitting the cycle after finish, or after the first byte offered on a full buffer.
// Backpress: din_ready is low while a full block is held or emitted; m_word/m_idx are held stable while m_ready=0.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, finish           one-cycle message start / end pulses
//   din, din_valid/ready    input byte handshake
//   m_word, m_idx           current block word and its index (0..15)
//   m_valid/m_ready         output word handshake
//   m_last                  m_idx == 15
//   m_final                 block is the last of the message
//   m_t                     message bytes up to and including this block
// Optional (BLOKE2B_PACKER_STATS_EN):
//   blk_cnt                 saturating count of blocks emitted since start
//   ovf_drop                sticky: a held-back byte was dropped by a coincident finish
module bloke2b_msg_packer #(
    parameter int CNT_W = 64,
    parameter int WORDS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             finish,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [63:0]      m_word,
    output logic [3:0]       m_idx,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             m_final,
    output logic [CNT_W-1:0] m_t
`ifdef BLOKE2B_PACKER_STATS_EN
    ,
    output logic [15:0]      blk_cnt,
    output logic             ovf_drop
`endif
);

    localparam int BLK_BYTES = WORDS * 8;
    localparam int FILL_W    = $clog2(BLK_BYTES + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(BLK_BYTES - 1);
    localparam logic [3:0]        IDX_LAST  = 4'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_HOLD,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [BLK_BYTES*8-1:0] r_buf;
    logic [FILL_W-1:0]      r_fill;
    logic [CNT_W-1:0]       r_t;
    logic [3:0]             r_idx;
    logic                   r_final;

    logic                   w_byte_xfer;
    logic                   w_word_xfer;
    logic                   w_blk_done;
    logic [FILL_W-2:0]      w_wr_pos;

    assign w_wr_pos    = r_fill[FILL_W-2:0];
    assign w_byte_xfer = din_valid && din_ready;
    assign w_word_xfer = m_valid && m_ready;
    assign w_blk_done  = w_word_xfer && (r_idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        // A start in the same cycle as a byte must not look like a handshake,
        // because the byte would be wiped by the clear.
        din_ready = (r_state == S_FILL) && !start;
        m_valid   = (r_state == S_EMIT);
        m_idx     = r_idx;
        m_word    = m_valid ? r_buf[{r_idx, 6'b000000} +: 64] : 64'd0;
        m_last    = m_valid && (r_idx == IDX_LAST);
        m_final   = m_valid && r_final;
        m_t       = r_t;

        case (r_state)
            S_IDLE: ;
            S_FILL: begin
                // The byte of this cycle is taken first; finish then closes the block.
                if (finish) begin
                    w_next = S_EMIT;
                end else if (w_byte_xfer && (r_fill == FILL_LAST)) begin
                    w_next = S_HOLD;
                end
            end
            // A full block waits here until we know whether it is the last one.
            S_HOLD: begin
                if (finish || din_valid) begin
                    w_next = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_blk_done) begin
                    w_next = r_final ? S_DONE : S_FILL;
                end
            end
            S_DONE: ;
            default: w_next = S_IDLE;
        endcase

        if (start) begin
            w_next = S_FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf   <= '0;
            r_fill  <= '0;
            r_t     <= '0;
            r_idx   <= '0;
            r_final <= 1'b0;
        end else if (start) begin
            r_buf   <= '0;
            r_fill  <= '0;
            r_t     <= '0;
            r_idx   <= '0;
            r_final <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_byte_xfer) begin
                        r_buf[{w_wr_pos, 3'b000} +: 8] <= din;
                        r_fill                         <= r_fill + 1'b1;
                        r_t                            <= r_t + 1'b1;
                    end
                    if (finish) begin
                        r_final <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (finish) begin
                        r_final <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (w_word_xfer) begin
                        r_idx <= r_idx + 4'd1;
                    end
                    // Zero the buffer so the next block's unfilled tail pads with zeros.
                    if (w_blk_done && !r_final) begin
                        r_buf  <= '0;
                        r_fill <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BLOKE2B_PACKER_STATS_EN
    logic [15:0] r_blk_cnt;
    logic        r_ovf_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk_cnt  <= '0;
            r_ovf_drop <= 1'b0;
        end else if (start) begin
            r_blk_cnt  <= '0;
            r_ovf_drop <= 1'b0;
        end else begin
            if (w_blk_done && (r_blk_cnt != 16'hFFFF)) begin
                r_blk_cnt <= r_blk_cnt + 16'd1;
            end
            if ((r_state == S_HOLD) && finish && din_valid) begin
                r_ovf_drop <= 1'b1;
            end
        end
    end

    assign blk_cnt  = r_blk_cnt;
    assign ovf_drop = r_ovf_drop;
`endif

endmodule

// File: tb/tb_bloke2b_msg_packer.sv
module tb_bloke2b_msg_packer;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        start     = 1'b0;
    logic        finish    = 1'b0;
    logic [7:0]  din       = 8'h00;
    logic        din_valid = 1'b0;
    logic        m_ready   = 1'b1;
    logic        din_ready;
    logic [63:0] m_word;
    logic [3:0]  m_idx;
    logic        m_valid;
    logic        m_last;
    logic        m_final;
    logic [63:0] m_t;

    int n_vec = 0;
    int n_err = 0;
    int rmode = 0;   // 0: m_ready high, 1: random, 2: repeating 1,0,0,1

    typedef struct packed {
        logic [63:0] w;
        logic [3:0]  idx;
        logic [63:0] t;
        logic        fin;
        logic        last;
    } rx_t;

    rx_t        rx_q[$];
    logic [7:0] msg_q[$];

    bloke2b_msg_packer #(.CNT_W(64), .WORDS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .finish    (finish),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .m_word    (m_word),
        .m_idx     (m_idx),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .m_final   (m_final),
        .m_t       (m_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: byte p of the message lands in word p/8 of block p/128 at lane p%8;
    // positions past the end of the message read as zero.
    function automatic logic [63:0] exp_word(input int b, input int w);
        logic [63:0] r;
        int          p;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            p = 128 * b + 8 * w + k;
            if (p < msg_q.size()) r[8*k +: 8] = msg_q[p];
        end
        return r;
    endfunction

    function automatic logic [63:0] rx_word(input int i);
        if (i < rx_q.size()) return rx_q[i].w;
        return 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    // m_ready driver
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1:       m_ready = 1'($urandom_range(0, 1));
                2:       begin m_ready = (ph == 0) || (ph == 3); ph = (ph + 1) % 4; end
                default: m_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: records transfers, checks hold-stability and no input during emit.
    initial begin
        logic        stall;
        logic [63:0] pw;
        logic [3:0]  pi;
        stall = 1'b0;
        pw    = '0;
        pi    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_valid", m_valid, 1);
                    chk("stall_word", m_word, pw);
                    chk("stall_idx", m_idx, pi);
                end
                if (m_valid) chk("rdy_in_emit", din_ready, 0);
                if (m_valid && m_ready) rx_q.push_back('{m_word, m_idx, m_t, m_final, m_last});
                stall = m_valid && !m_ready;
                pw    = m_word;
                pi    = m_idx;
            end
        end
    end

    task automatic send_msg(input bit coincide, input bit gaps);
        int n;
        bit acc;
        bit fin_sent;
        n        = msg_q.size();
        fin_sent = 1'b0;
        @(posedge clk); #1;
        rx_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            din       = msg_q[i];
            din_valid = 1'b1;
            acc       = 1'b0;
            for (int c = 0; c < 2000 && !acc; c++) begin
                @(negedge clk);
                if (din_ready) begin
                    acc = 1'b1;
                    if (coincide && i == n - 1) begin
                        finish   = 1'b1;
                        fin_sent = 1'b1;
                    end
                end
                @(posedge clk); #1;
            end
            din_valid = 1'b0;
            finish    = 1'b0;
            if (!acc) chk("din_timeout", 0, 1);
        end
        if (!fin_sent) begin
            @(negedge clk);
            chk("pre_fin_valid", m_valid, 0);
            chk("pre_fin_rdy", din_ready, 64'((n == 0) || (n % 128 != 0)));
            @(posedge clk); #1;
            finish = 1'b1;
            @(posedge clk); #1;
            finish = 1'b0;
        end
    endtask

    task automatic check_msg();
        int n;
        int nb;
        int cyc;
        int b;
        int w;
        n   = msg_q.size();
        nb  = (n == 0) ? 1 : (n + 127) / 128;
        cyc = 0;
        while (rx_q.size() < nb * 16 && cyc < 6000) begin
            @(posedge clk);
            cyc++;
        end
        chk("blk_timeout", 64'(rx_q.size() >= nb * 16), 1);
        repeat (20) @(posedge clk);
        chk("xfer_count", 64'(rx_q.size()), 64'(nb * 16));
        @(negedge clk);
        chk("done_valid", m_valid, 0);
        for (int i = 0; i < rx_q.size() && i < nb * 16; i++) begin
            b = i / 16;
            w = i % 16;
            chk("idx", rx_q[i].idx, 64'(w));
            chk("word", rx_q[i].w, exp_word(b, w));
            chk("t", rx_q[i].t, 64'((b == nb - 1) ? n : 128 * (b + 1)));
            chk("final", rx_q[i].fin, 64'(b == nb - 1));
            chk("last", rx_q[i].last, 64'(w == 15));
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;
        int cyc;
        int n;

        // Reset values
        #1 rst_n = 1'b0;
        #3;
        chk("rst_din_ready", din_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_final", m_final, 0);
        chk("rst_m_idx", m_idx, 0);
        chk("rst_m_word", m_word, 0);
        chk("rst_m_t", m_t, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Empty message
        msg_q.delete();
        rmode = 0;
        send_msg(0, 0);
        check_msg();

        // "abc"
        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg(0, 0);
        check_msg();
        chk("abc_w0", rx_word(0), 64'h0000_0000_0063_6261);

        // 128 bytes 0x00..0x7F: full block held until finish
        msg_q.delete();
        for (int i = 0; i < 128; i++) msg_q.push_back(8'(i));
        send_msg(0, 0);
        check_msg();
        chk("b128_w0", rx_word(0), 64'h0706_0504_0302_0100);
        chk("b128_w15", rx_word(15), 64'h7F7E_7D7C_7B7A_7978);

        // 129 bytes: 129th byte forces a non-final block out first
        msg_q.push_back(8'h80);
        send_msg(0, 0);
        check_msg();
        chk("b129_w16", rx_word(16), 64'h0000_0000_0000_0080);

        // "abc" with m_ready pattern 1,0,0,1
        msg_q = '{8'h61, 8'h62, 8'h63};
        rmode = 2;
        send_msg(0, 0);
        check_msg();
        rmode = 0;

        // Reset in the middle of a block, then "123"
        send_msg(0, 0);
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 200) begin
            @(negedge clk);
            if (m_valid && m_idx == 4'd5) found = 1'b1;
            cyc++;
        end
        chk("rst_wait", found, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_idx", m_idx, 0);
        chk("mid_rst_word", m_word, 0);
        chk("mid_rst_t", m_t, 0);
        chk("mid_rst_final", m_final, 0);
        chk("mid_rst_last", m_last, 0);
        chk("mid_rst_rdy", din_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        msg_q = '{8'h31, 8'h32, 8'h33};
        send_msg(0, 0);
        check_msg();
        chk("r123_w0", rx_word(0), 64'h0000_0000_0033_3231);

        // Randomized messages including block-size boundaries
        for (int m = 0; m < 7; m++) begin
            n = (m == 0) ? 256 : (m == 1) ? 255 : (m == 2) ? 1 : $urandom_range(0, 300);
            msg_q.delete();
            for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
            rmode = m % 3;
            send_msg((n > 0) && ($urandom_range(0, 1) == 1), 1);
            check_msg();
        end
        rmode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
